// File: rtl/fault_campaign_controller.sv
// fault_campaign_controller
//   On-chip self-test sequencer for the 13-bit Hamming SEC-DED path
//   (encoder -> two-bit fault injector -> decoder). For every test it drives
//   a data word and a fault location, waits for the decoder to settle,
//   samples the decoder flags and keeps pass/fail tallies plus the first
//   failing fault location.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, mode         campaign request (IDLE only) and campaign select
//   data_word           test pattern, latched on an accepted start
//   enc_data            latched pattern to the encoder
//   fault_en, is_two_bit_fault, fault_bit_addr1/2   injector controls
//   dec_data, dec_single_err, dec_double_err        decoder results
//   busy, done          campaign running / one-cycle completion pulse
//   pass_count, fail_count                          saturating tallies
//   fail_valid, first_fail_addr1/2, first_fail_type first-failure capture
module fault_campaign_controller #(
   parameter int DATA_WIDTH    = 8,
   parameter int CODE_WIDTH    = 13,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] data_word,
   output logic [DATA_WIDTH-1:0] enc_data,
   output logic                  fault_en,
   output logic                  is_two_bit_fault,
   output logic [3:0]            fault_bit_addr1,
   output logic [3:0]            fault_bit_addr2,
   input  logic [DATA_WIDTH-1:0] dec_data,
   input  logic                  dec_single_err,
   input  logic                  dec_double_err,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            pass_count,
   output logic [7:0]            fail_count,
   output logic                  fail_valid,
   output logic [3:0]            first_fail_addr1,
   output logic [3:0]            first_fail_addr2,
   output logic [1:0]            first_fail_type
);

   localparam logic [3:0] LAST_ADDR = 4'(CODE_WIDTH - 1);
   localparam logic [3:0] WAIT_LOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t      state_r;
   logic [1:0]  mode_r;
   logic [1:0]  phase_r;
   logic [3:0]  wait_cnt_r;

   logic [1:0]  first_phase_s;
   logic [3:0]  first_addr2_s;
   logic [1:0]  nxt_phase_s;
   logic [3:0]  nxt_addr1_s;
   logic [3:0]  nxt_addr2_s;
   logic        last_s;
   logic        pass_s;

   // First vector of a campaign, selected by the requested mode.
   always_comb begin
      first_phase_s = 2'd0;
      first_addr2_s = 4'd0;
      case (mode)
         2'd1: begin
            first_phase_s = 2'd1;
            first_addr2_s = 4'd0;
         end
         2'd2: begin
            first_phase_s = 2'd2;
            first_addr2_s = 4'd1;
         end
         default: begin
            first_phase_s = 2'd0;
            first_addr2_s = 4'd0;
         end
      endcase
   end

   // Successor of the current vector; last_s flags the final test of the campaign.
   always_comb begin
      nxt_phase_s = phase_r;
      nxt_addr1_s = fault_bit_addr1;
      nxt_addr2_s = fault_bit_addr2;
      last_s      = 1'b0;
      case (phase_r)
         2'd0: begin
            if (mode_r == 2'd3) begin
               nxt_phase_s = 2'd1;
               nxt_addr1_s = 4'd0;
               nxt_addr2_s = 4'd0;
            end else begin
               last_s = 1'b1;
            end
         end
         2'd1: begin
            if (fault_bit_addr1 != LAST_ADDR) begin
               nxt_addr1_s = fault_bit_addr1 + 4'd1;
            end else if (mode_r == 2'd3) begin
               nxt_phase_s = 2'd2;
               nxt_addr1_s = 4'd0;
               nxt_addr2_s = 4'd1;
            end else begin
               last_s = 1'b1;
            end
         end
         2'd2: begin
            // addr2 is the inner loop; a new outer addr1 restarts addr2 just above it.
            if (fault_bit_addr2 != LAST_ADDR) begin
               nxt_addr2_s = fault_bit_addr2 + 4'd1;
            end else if (fault_bit_addr1 != (LAST_ADDR - 4'd1)) begin
               nxt_addr1_s = fault_bit_addr1 + 4'd1;
               nxt_addr2_s = fault_bit_addr1 + 4'd2;
            end else begin
               last_s = 1'b1;
            end
         end
         default: begin
            last_s = 1'b1;
         end
      endcase
   end

   // Pass criterion for the current phase; corrected data is meaningless after a double fault.
   always_comb begin
      pass_s = 1'b0;
      case (phase_r)
         2'd0:    pass_s = (dec_data == enc_data) && !dec_single_err && !dec_double_err;
         2'd1:    pass_s = (dec_data == enc_data) &&  dec_single_err && !dec_double_err;
         2'd2:    pass_s = dec_double_err && !dec_single_err;
         default: pass_s = 1'b0;
      endcase
   end

   // Campaign FSM with registered vector, status, tally and capture outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         mode_r           <= 2'd0;
         phase_r          <= 2'd0;
         wait_cnt_r       <= 4'd0;
         enc_data         <= '0;
         fault_en         <= 1'b0;
         is_two_bit_fault <= 1'b0;
         fault_bit_addr1  <= 4'd0;
         fault_bit_addr2  <= 4'd0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass_count       <= 8'd0;
         fail_count       <= 8'd0;
         fail_valid       <= 1'b0;
         first_fail_addr1 <= 4'd0;
         first_fail_addr2 <= 4'd0;
         first_fail_type  <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  mode_r           <= mode;
                  enc_data         <= data_word;
                  phase_r          <= first_phase_s;
                  fault_en         <= (first_phase_s != 2'd0);
                  is_two_bit_fault <= (first_phase_s == 2'd2);
                  fault_bit_addr1  <= 4'd0;
                  fault_bit_addr2  <= first_addr2_s;
                  pass_count       <= 8'd0;
                  fail_count       <= 8'd0;
                  fail_valid       <= 1'b0;
                  first_fail_addr1 <= 4'd0;
                  first_fail_addr2 <= 4'd0;
                  first_fail_type  <= 2'd0;
                  busy             <= 1'b1;
                  state_r          <= ST_APPLY;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_APPLY: begin
               wait_cnt_r <= WAIT_LOAD;
               state_r    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt_r == 4'd0) begin
                  state_r <= ST_CHECK;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            ST_CHECK: begin
               if (pass_s) begin
                  if (pass_count != 8'hFF) begin
                     pass_count <= pass_count + 8'd1;
                  end else begin
                     pass_count <= pass_count;
                  end
               end else begin
                  if (fail_count != 8'hFF) begin
                     fail_count <= fail_count + 8'd1;
                  end else begin
                     fail_count <= fail_count;
                  end
                  if (!fail_valid) begin
                     fail_valid       <= 1'b1;
                     first_fail_addr1 <= fault_bit_addr1;
                     first_fail_addr2 <= fault_bit_addr2;
                     first_fail_type  <= phase_r;
                  end else begin
                     fail_valid <= fail_valid;
                  end
               end
               if (last_s) begin
                  // Injector is released once the campaign has finished.
                  fault_en         <= 1'b0;
                  is_two_bit_fault <= 1'b0;
                  fault_bit_addr1  <= 4'd0;
                  fault_bit_addr2  <= 4'd0;
                  busy             <= 1'b0;
                  done             <= 1'b1;
                  state_r          <= ST_DONE;
               end else begin
                  phase_r          <= nxt_phase_s;
                  fault_en         <= (nxt_phase_s != 2'd0);
                  is_two_bit_fault <= (nxt_phase_s == 2'd2);
                  fault_bit_addr1  <= nxt_addr1_s;
                  fault_bit_addr2  <= nxt_addr2_s;
                  state_r          <= ST_APPLY;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fault_campaign_controller.md
Name: fault_campaign_controller

Overview:
- Sequences an exhaustive fault-injection campaign over the 13-bit Hamming SEC-DED path: encoder → two-bit fault injector → decoder.
- For each test it drives the data word to the encoder and the fault controls to the injector, waits for the decoder to settle, then checks the decoder flags and corrected data.
- Keeps pass/fail tallies and captures the first failing fault location; serves as the on-chip self-test for the protection code.

Parameters:
- DATA_WIDTH, 8, data bits carried by the codeword.
- CODE_WIDTH, 13, codeword bits; fault addresses run 0..CODE_WIDTH-1.
- SETTLE_CYCLES, 2, cycles between applying a test vector and sampling the decoder; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a campaign; honoured only in IDLE.
- mode  in  2  campaign select: 0 no-fault, 1 all single faults, 2 all double faults, 3 all three in order 0→1→2.
- data_word  in  DATA_WIDTH  test pattern, latched on an accepted start.
- enc_data  out  DATA_WIDTH  latched pattern, driven to the encoder.
- fault_en  out  1  to injector.
- is_two_bit_fault  out  1  to injector.
- fault_bit_addr1  out  4  to injector.
- fault_bit_addr2  out  4  to injector.
- dec_data  in  DATA_WIDTH  decoder corrected data.
- dec_single_err  in  1  decoder single-error (corrected) flag.
- dec_double_err  in  1  decoder double-error (detected) flag.
- busy  out  1  campaign in progress.
- done  out  1  one-cycle completion pulse.
- pass_count  out  8  tests passed.
- fail_count  out  8  tests failed.
- fail_valid  out  1  at least one failure captured.
- first_fail_addr1  out  4  addr1 of the first failing test.
- first_fail_addr2  out  4  addr2 of the first failing test.
- first_fail_type  out  2  phase of the first failing test (0, 1 or 2).

Behaviour:
- Reset, applied asynchronously: state IDLE; all outputs 0, including fault_en, counts and capture registers.
- States and transitions:
  - IDLE: on start, latch mode and data_word, clear counts and capture registers, load the first vector, go to APPLY. busy rises the cycle after start.
  - APPLY: 1 cycle with the vector driven, then WAIT.
  - WAIT: exactly SETTLE_CYCLES cycles on a down-counter, then CHECK.
  - CHECK: 1 cycle; sample the decoder, update counts, advance the vector; go to APPLY, or to DONE after the last vector.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Vector registers hold steady from APPLY through CHECK, so each test takes SETTLE_CYCLES+2 cycles.
- Phase 0 (no fault): 1 test; fault_en=0, is_two_bit_fault=0, addr1=addr2=0.
  - Pass iff dec_data==enc_data, single=0, double=0.
- Phase 1 (single fault): addr1 runs 0..12, addr2=0; fault_en=1, is_two_bit_fault=0; 13 tests.
  - Pass iff dec_data==enc_data, single=1, double=0.
- Phase 2 (double fault): all pairs with addr1<addr2, ordered addr1 0..11 outer and addr2 addr1+1..12 inner; fault_en=1, is_two_bit_fault=1; 78 tests.
  - Pass iff double=1 and single=0; dec_data is not checked.
- Campaign lengths: mode 3 runs phases 0, 1, 2 back to back for 92 tests; pass_count+fail_count equals the test count at done.
- Counts saturate at 255. This is unreachable for legal runs but required.
- First-failure capture:
  - Taken on the first failing CHECK only; fail_valid is set then.
  - Later failures increment fail_count but do not overwrite the capture.
- start while busy or in DONE: ignored, with no effect on state or latched inputs.
- Results hold after done until the next accepted start clears them.
- Reset mid-campaign: fault_en drops asynchronously, all state clears, and no done pulse is produced.
- Decoder inputs are sampled only in CHECK; their values in other states are don't-care.

Test Plan:
- Ideal decoder model with SETTLE_CYCLES=2, mode=1, data_word=8'hA5 → addr1 sequence 0..12, done 52 cycles after the first APPLY, pass_count=13, fail_count=0, fail_valid=0.
- Ideal decoder, mode=3, data_word=8'h3C → 92 tests; pass_count=92; first double-fault vector is (0,1), last is (11,12); done pulse exactly 1 cycle wide.
- Decoder model forcing single=0 when the fault is at bit 7, mode=1 → fail_count=1, pass_count=12, fail_valid=1, first_fail_addr1=7, first_fail_type=1.
- Decoder model failing pairs (2,5) and (4,9), mode=2 → fail_count=2, first_fail_addr1=2, first_fail_addr2=5, first_fail_type=2.
- Assert rst during WAIT of test 5, mode=1 → fault_en=0 immediately, counts=0, busy=0, no done; a subsequent start with mode=0 gives pass_count=1.
- Pulse start again 3 cycles into a mode=2 run with mode=0 → ignored; run completes as 78 double-fault tests.
